// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: machine word, fetch FSM encoding and the reset fetch address.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DROP
  } fetch_state_t;

  localparam rv32i_word FETCH_RESET_PC = 32'h0000_0060;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic rv32i_word word_align(input rv32i_word addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Enabled pc+instruction register that buffers a fetched word while the backend stalls.
module fetch_hold_buf
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  rv32i_word pc_d,
  input  rv32i_word instr_d,
  output rv32i_word pc_q,
  output rv32i_word instr_q
);

  logic [63:0] buf_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (en) begin
      buf_q <= {pc_d, instr_d};
    end
  end

  assign pc_q    = buf_q[63:32];
  assign instr_q = buf_q[31:0];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, runs the I-cache read/resp handshake,
// buffers a fetched word across backend stalls and absorbs redirects during outstanding reads.
module fetch_unit
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = FETCH_RESET_PC
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      stall_i,
  input  logic      redirect_i,
  input  rv32i_word redirect_pc_i,
  output logic      imem_read_o,
  output rv32i_word imem_address_o,
  input  logic      imem_resp_i,
  input  rv32i_word imem_rdata_i,
  output logic      if_valid_o,
  output rv32i_word if_pc_o,
  output rv32i_word if_instr_o,
  output logic      if_id_en_o
);

  fetch_state_t state_q, state_d;
  rv32i_word    pc_q, pc_d;
  rv32i_word    tgt_q, tgt_d;
  rv32i_word    hold_pc_q, hold_instr_q;
  rv32i_word    target;
  logic         hold_en;

  assign target = word_align(redirect_pc_i);

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (hold_en),
    .pc_d    (pc_q),
    .instr_d (imem_rdata_i),
    .pc_q    (hold_pc_q),
    .instr_q (hold_instr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    hold_en = 1'b0;
    case (state_q)
      REQ: begin
        if (redirect_i) begin
          if (imem_resp_i) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = DROP;
          end
        end else if (imem_resp_i) begin
          if (stall_i) begin
            hold_en = 1'b1;
            state_d = HOLD;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!stall_i) begin
          pc_d    = hold_pc_q + 32'd4;
          state_d = REQ;
        end
      end
      DROP: begin
        if (imem_resp_i) begin
          pc_d    = redirect_i ? target : tgt_q;
          state_d = REQ;
        end else if (redirect_i) begin
          tgt_d = target;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Outputs are gated by rst_n so they clear the instant reset asserts, not at the next edge.
  always_comb begin
    imem_read_o    = 1'b0;
    imem_address_o = '0;
    if_valid_o     = 1'b0;
    if_pc_o        = '0;
    if_instr_o     = '0;
    if (rst_n) begin
      imem_address_o = pc_q;
      case (state_q)
        REQ: begin
          imem_read_o = 1'b1;
          if (imem_resp_i && !redirect_i) begin
            if_valid_o = 1'b1;
            if_pc_o    = pc_q;
            if_instr_o = imem_rdata_i;
          end
        end
        HOLD: begin
          if (!redirect_i) begin
            if_valid_o = 1'b1;
            if_pc_o    = hold_pc_q;
            if_instr_o = hold_instr_q;
          end
        end
        DROP:    imem_read_o = 1'b1;
        default: imem_read_o = 1'b0;
      endcase
    end
  end

  assign if_id_en_o = !stall_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_fetch_unit;
  import rv32i_types::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      stall_i;
  logic      redirect_i;
  rv32i_word redirect_pc_i;
  logic      imem_read_o;
  rv32i_word imem_address_o;
  logic      imem_resp_i;
  rv32i_word imem_rdata_i;
  logic      if_valid_o;
  rv32i_word if_pc_o;
  rv32i_word if_instr_o;
  logic      if_id_en_o;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_read_o    (imem_read_o),
    .imem_address_o (imem_address_o),
    .imem_resp_i    (imem_resp_i),
    .imem_rdata_i   (imem_rdata_i),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_instr_o     (if_instr_o),
    .if_id_en_o     (if_id_en_o)
  );

  always #5 clk = ~clk;

  function automatic rv32i_word mem_word(input rv32i_word a);
    if (a == 32'h0000_0064) return 32'h00A0_0093;
    return {a[15:0], 16'h0013};
  endfunction

  // Advance to the next falling edge and return all driven inputs to idle.
  task automatic cyc();
    @(negedge clk);
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_resp_i   = 1'b0;
    imem_rdata_i  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_resp_i = 1'b1; imem_rdata_i = 32'hFFFF_FFFF;
    #1;
    checks++; if (imem_read_o !== 1'b0) begin errors++; $display("FAIL reset_read: got %0b want 0", imem_read_o); end
    checks++; if (imem_address_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_address_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc_o); end
    checks++; if (if_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_instr_o); end
    checks++; if (if_id_en_o !== 1'b1) begin errors++; $display("FAIL reset_en_nostall: got %0b want 1", if_id_en_o); end
    stall_i = 1'b1;
    #1;
    checks++; if (if_id_en_o !== 1'b0) begin errors++; $display("FAIL reset_en_stall: got %0b want 0", if_id_en_o); end
    cyc();
  endtask

  task automatic test_straight_line();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rv32i_word exp_a;
      exp_a = 32'h60 + 32'(4 * i);
      imem_resp_i = 1'b1; imem_rdata_i = mem_word(exp_a);
      #1;
      checks++; if (imem_read_o !== 1'b1) begin errors++; $display("FAIL straight_read[%0d]: got %0b want 1", i, imem_read_o); end
      checks++; if (imem_address_o !== exp_a) begin errors++; $display("FAIL straight_addr[%0d]: got %h want %h", i, imem_address_o, exp_a); end
      checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL straight_valid[%0d]: got %0b want 1", i, if_valid_o); end
      checks++; if (if_pc_o !== exp_a) begin errors++; $display("FAIL straight_pc[%0d]: got %h want %h", i, if_pc_o, exp_a); end
      checks++; if (if_instr_o !== mem_word(exp_a)) begin errors++; $display("FAIL straight_instr[%0d]: got %h want %h", i, if_instr_o, mem_word(exp_a)); end
      cyc();
    end
  endtask

  task automatic test_stall();
    // Restart from RESET_PC with a pulse placed between clock edges.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h60);
    #1;
    checks++; if (imem_address_o !== 32'h60) begin errors++; $display("FAIL stall_restart_addr: got %h want 00000060", imem_address_o); end
    cyc();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h64); stall_i = 1'b1;
    #1;
    checks++; if (imem_address_o !== 32'h64) begin errors++; $display("FAIL stall_resp_addr: got %h want 00000064", imem_address_o); end
    checks++; if (if_id_en_o !== 1'b0) begin errors++; $display("FAIL stall_resp_en: got %0b want 0", if_id_en_o); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      stall_i = (i < 2);
      #1;
      checks++; if (imem_read_o !== 1'b0) begin errors++; $display("FAIL hold_read[%0d]: got %0b want 0", i, imem_read_o); end
      checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %0b want 1", i, if_valid_o); end
      checks++; if (if_instr_o !== 32'h00A0_0093) begin errors++; $display("FAIL hold_instr[%0d]: got %h want 00a00093", i, if_instr_o); end
      checks++; if (if_pc_o !== 32'h64) begin errors++; $display("FAIL hold_pc[%0d]: got %h want 00000064", i, if_pc_o); end
      checks++; if (if_id_en_o !== !stall_i) begin errors++; $display("FAIL hold_en[%0d]: got %0b want %0b", i, if_id_en_o, !stall_i); end
      cyc();
    end
    #1;
    checks++; if (imem_read_o !== 1'b1) begin errors++; $display("FAIL after_hold_read: got %0b want 1", imem_read_o); end
    checks++; if (imem_address_o !== 32'h68) begin errors++; $display("FAIL after_hold_addr: got %h want 00000068", imem_address_o); end
  endtask

  task automatic test_redirect_wait();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h68);
    cyc();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h6C);
    cyc();
    // 3-cycle memory: read at 0x70 answers in its third cycle.
    #1;
    checks++; if (imem_address_o !== 32'h70 || if_valid_o !== 1'b0) begin errors++; $display("FAIL wait_c1: got addr %h valid %0b want 00000070 0", imem_address_o, if_valid_o); end
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    checks++; if (imem_address_o !== 32'h70 || if_valid_o !== 1'b0) begin errors++; $display("FAIL wait_redirect: got addr %h valid %0b want 00000070 0", imem_address_o, if_valid_o); end
    cyc();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h70);
    #1;
    checks++; if (imem_read_o !== 1'b1 || imem_address_o !== 32'h70) begin errors++; $display("FAIL drop_addr: got read %0b addr %h want 1 00000070", imem_read_o, imem_address_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL drop_valid: got %0b want 0", if_valid_o); end
    cyc();
    #1;
    checks++; if (imem_read_o !== 1'b1 || imem_address_o !== 32'h200) begin errors++; $display("FAIL post_drop_addr: got read %0b addr %h want 1 00000200", imem_read_o, imem_address_o); end
  endtask

  task automatic test_double_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    #1;
    checks++; if (imem_address_o !== 32'h200) begin errors++; $display("FAIL dbl_addr_stable: got %h want 00000200", imem_address_o); end
    cyc();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h200);
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL dbl_drop_valid: got %0b want 0", if_valid_o); end
    cyc();
    #1;
    checks++; if (imem_address_o !== 32'h300) begin errors++; $display("FAIL dbl_next_addr: got %h want 00000300", imem_address_o); end
  endtask

  task automatic test_redirect_resp_stall();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h300); stall_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rrs_valid: got %0b want 0", if_valid_o); end
    cyc();
    #1;
    checks++; if (imem_read_o !== 1'b1) begin errors++; $display("FAIL rrs_no_hold: got read %0b want 1", imem_read_o); end
    checks++; if (imem_address_o !== 32'h200) begin errors++; $display("FAIL rrs_aligned_addr: got %h want 00000200", imem_address_o); end
  endtask

  task automatic test_wrap_and_async_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h200);
    cyc();
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'hFFFF_FFFC);
    #1;
    checks++; if (imem_address_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_address_o); end
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_present: got valid %0b pc %h want 1 fffffffc", if_valid_o, if_pc_o); end
    cyc();
    #1;
    checks++; if (imem_address_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 00000000", imem_address_o); end
    // Park in DROP, then reset between clock edges.
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_read_o !== 1'b0) begin errors++; $display("FAIL async_read: got %0b want 0", imem_read_o); end
    checks++; if (imem_address_o !== 32'h0) begin errors++; $display("FAIL async_addr: got %h want 00000000", imem_address_o); end
    checks++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin errors++; $display("FAIL async_if: got valid %0b pc %h instr %h want 0 0 0", if_valid_o, if_pc_o, if_instr_o); end
    cyc();
    rst_n = 1'b1;
    imem_resp_i = 1'b1; imem_rdata_i = mem_word(32'h60);
    #1;
    checks++; if (imem_read_o !== 1'b1 || imem_address_o !== 32'h60) begin errors++; $display("FAIL post_reset_addr: got read %0b addr %h want 1 00000060", imem_read_o, imem_address_o); end
    checks++; if (if_valid_o !== 1'b1 || if_instr_o !== mem_word(32'h60)) begin errors++; $display("FAIL post_reset_fetch: got valid %0b instr %h want 1 %h", if_valid_o, if_instr_o, mem_word(32'h60)); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect_wait();
    test_double_redirect();
    test_redirect_resp_stall();
    test_wrap_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I pipeline. Owns the program counter, runs the read/resp handshake with the instruction memory (I-cache), and presents one fetched instruction per response to the IF/ID pipeline register together with that register's load enable. Handles backend stalls by holding the fetched word locally, and handles branch/jump redirects, including redirects that arrive while a read is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0060: first fetch address after reset.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst_n`  in  1  **asynchronous, active-low** reset.
- `stall_i`  in  1  backend cannot accept; IF/ID must hold.
- `redirect_i`  in  1  taken branch/jump or flush from EX.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `imem_read_o`  out  1  read request; held high with a stable address until `imem_resp_i`.
- `imem_address_o`  out  32  word-aligned fetch address.
- `imem_resp_i`  in  1  one-cycle pulse; `imem_rdata_i` valid in that cycle.
- `imem_rdata_i`  in  32  instruction word.
- `if_valid_o`  out  1  `if_pc_o` and `if_instr_o` are a real instruction, not a bubble.
- `if_pc_o`  out  32  PC of the presented instruction.
- `if_instr_o`  out  32  instruction presented to IF/ID.
- `if_id_en_o`  out  1  IF/ID load enable; equals `!stall_i`.

## Operation
- Registers: `pc_q` (next fetch address), `hold_pc_q`/`hold_instr_q` (buffered instruction), `tgt_q` (pending redirect target), and state.
- FSM states:
  - **REQ**: `imem_read_o`=1, `imem_address_o`=`pc_q`.
  - **HOLD**: a fetched word is waiting on a stall. `imem_read_o`=0.
  - **DROP**: an outstanding read was made stale by a redirect. `imem_read_o`=1, address stays at the old `pc_q`.
- **Redirect priority:** `redirect_i` beats everything in every state. `if_valid_o`=0 in that cycle.
- **REQ transitions:**
  - redirect, no resp → `tgt_q`←target, go DROP.
  - redirect with resp → discard the word, `pc_q`←target, stay in REQ.
  - resp, no stall → present `pc_q`/`imem_rdata_i` combinationally with `if_valid_o`=1; `pc_q`←`pc_q`+4; stay in REQ.
  - resp with stall → `hold_*`←(`pc_q`, `imem_rdata_i`); go HOLD.
  - no resp → hold the address, `if_valid_o`=0.
- **HOLD transitions:**
  - outputs: `if_valid_o`=1 with the `hold_*` contents.
  - `!stall_i` → IF/ID loads the held word, `pc_q`←`hold_pc_q`+4, go REQ.
  - redirect → discard the held word, `pc_q`←target, go REQ.
- **DROP transitions:**
  - outputs: `if_valid_o`=0.
  - a further redirect overwrites `tgt_q`.
  - on resp → discard the word, `pc_q`←`tgt_q` (or the new target if a redirect arrives in the same cycle), go REQ.
- **Arithmetic:** PC+4 is modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.

## Timing
- **Reset:** while `rst_n`=0:
  - all outputs are 0: `imem_read_o`, `if_valid_o`, `if_pc_o`, `if_instr_o`, `imem_address_o`.
  - `if_id_en_o` follows `!stall_i`.
  - `pc_q`=`RESET_PC`, state=REQ.
- **Reset mid-operation:** any outstanding read is abandoned (memory is reset alongside). The first cycle after deassertion issues a read at `RESET_PC`.
- **Latency:** the instruction appears at `if_*` in the same cycle as `imem_resp_i`, and is captured by IF/ID at that edge.
- **Throughput:** with a single-cycle-response memory, one instruction per cycle.
- **Next request:** issued the cycle after a consumed response.
- **Stall:** no new read is issued while in HOLD.
- **Address stability:** `imem_address_o` never changes while `imem_read_o`=1 and no resp has arrived.

## Structure
- Shared package `rv32i_types`:
  - `rv32i_word` typedef (logic [31:0]).
  - `fetch_state_t` enum {REQ, HOLD, DROP}.
  - `FETCH_RESET_PC` constant, used as the `RESET_PC` default.
- One sub-module: `fetch_hold_buf`, an enabled 64-bit (pc+instr) register with async active-low reset, instantiated for `hold_*`.
- The FSM and PC logic stay in `fetch_unit`.

## Test plan
- **Reset and straight-line fetch:** release reset with a 1-cycle-response memory → reads at 0x60, 0x64, 0x68 on consecutive cycles; `if_valid_o`=1 each cycle.
- **Stall during resp:** assert `stall_i` in the cycle resp returns 0x00A00093 at 0x64, then deassert after 3 cycles → `if_instr_o` holds 0x00A00093 with `imem_read_o`=0 for 3 cycles; the next read is at 0x68.
- **Redirect while waiting (3-cycle memory):** redirect to 0x200 one cycle after a read at 0x70 → address stays 0x70 until resp; that word is dropped with `if_valid_o`=0; the next read is at 0x200.
- **Double redirect in DROP:** redirect to 0x200, then to 0x300 before resp → the next read is at 0x300.
- **Redirect coincident with resp and stall:** → no HOLD entry; `if_valid_o`=0; the next read is at the target with bits [1:0] cleared (0x203 → 0x200).
- **Wrap-around and async reset:** a redirect to 0xFFFF_FFFC followed by a resp → the next read is at 0x0. Asserting `rst_n`=0 mid-read then clears all outputs immediately, without waiting for a clock edge.
